// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one serial TX channel between the instruction
// scheduler (SC) and the instruction prefetcher (PF). SC has priority, a
// grant lasts one transaction, and the owner of an outstanding RX reply is
// remembered so reply data can be steered back to the right requester.
module tx_arbiter #(
   parameter int NSHIFT   = 2,
   parameter int CMD_BITS = 2
) (
   input  logic                clk,
   input  logic                reset,
   // scheduler side
   input  logic                sc_reserve,
   input  logic                sc_valid,
   input  logic [CMD_BITS-1:0] sc_command,
   input  logic                sc_reply_wanted,
   input  logic [NSHIFT-1:0]   sc_data,
   output logic                sc_started,
   output logic                sc_data_next,
   output logic                sc_done,
   // prefetcher side
   input  logic                pf_valid,
   input  logic [CMD_BITS-1:0] pf_command,
   input  logic                pf_reply_wanted,
   input  logic [NSHIFT-1:0]   pf_data,
   output logic                pf_started,
   output logic                pf_data_next,
   output logic                pf_done,
   // TX engine side
   output logic                tx_command_valid,
   output logic [CMD_BITS-1:0] tx_command,
   output logic                tx_reply_wanted,
   output logic [NSHIFT-1:0]   tx_data,
   input  logic                tx_command_started,
   input  logic                tx_data_next,
   input  logic                tx_done,
   // reply tracking
   input  logic                rx_done,
   output logic                reply_pending,
   output logic                reply_owner
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] GRANT_SC = 2'd1;
   localparam logic [1:0] GRANT_PF = 2'd2;

   logic [1:0] state_q, state_d;
   logic       reply_pending_q, reply_pending_d;
   logic       reply_owner_q, reply_owner_d;
   logic       sc_free_s, pf_free_s, start_ok_s;

   // A requester can use the channel unless it wants a reply while one is already outstanding.
   assign sc_free_s = ~reply_pending_q | ~sc_reply_wanted;
   assign pf_free_s = ~reply_pending_q | ~pf_reply_wanted;

   // A start strobe without a valid command is a protocol error and is dropped.
   assign start_ok_s = tx_command_started & tx_command_valid;

   assign reply_pending = reply_pending_q;
   assign reply_owner   = reply_owner_q;

   // Route the grantee's command/payload to the TX engine and its strobes back; everything else reads 0.
   always_comb begin
      tx_command_valid = 1'b0;
      tx_command       = {CMD_BITS{1'b0}};
      tx_reply_wanted  = 1'b0;
      tx_data          = {NSHIFT{1'b0}};
      sc_started       = 1'b0;
      sc_data_next     = 1'b0;
      sc_done          = 1'b0;
      pf_started       = 1'b0;
      pf_data_next     = 1'b0;
      pf_done          = 1'b0;
      case (state_q)
         GRANT_SC: begin
            tx_command_valid = sc_valid;
            tx_command       = sc_command;
            tx_reply_wanted  = sc_reply_wanted;
            tx_data          = sc_data;
            sc_started       = tx_command_started & sc_valid;
            sc_data_next     = tx_data_next;
            sc_done          = tx_done;
         end
         GRANT_PF: begin
            tx_command_valid = pf_valid;
            tx_command       = pf_command;
            tx_reply_wanted  = pf_reply_wanted;
            tx_data          = pf_data;
            pf_started       = tx_command_started & pf_valid;
            pf_data_next     = tx_data_next;
            pf_done          = tx_done;
         end
         default: begin
            tx_command_valid = 1'b0;
         end
      endcase
   end

   // Arbitration: SC first, PF only when SC is neither requesting nor reserving; release on tx_done.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (sc_valid && sc_free_s) begin
               state_d = GRANT_SC;
            end else if (pf_valid && !sc_valid && !sc_reserve && pf_free_s) begin
               state_d = GRANT_PF;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT_SC, GRANT_PF: begin
            if (tx_done) begin
               state_d = IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reply tracking: an accepted reply-wanting command sets pending (beating a same-cycle rx_done).
   always_comb begin
      reply_pending_d = reply_pending_q;
      reply_owner_d   = reply_owner_q;
      if (start_ok_s && tx_reply_wanted) begin
         reply_pending_d = 1'b1;
         reply_owner_d   = (state_q == GRANT_SC);
      end else if (rx_done) begin
         reply_pending_d = 1'b0;
      end else begin
         reply_pending_d = reply_pending_q;
      end
   end

   // State registers; reset drops any grant without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         reply_pending_q <= 1'b0;
         reply_owner_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         reply_pending_q <= reply_pending_d;
         reply_owner_q   <= reply_owner_d;
      end
   end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed, table-driven bench for tx_arbiter. Each table
// row is one clock cycle of inputs plus the outputs expected in that cycle.
// Outputs are packed as
// {cv, cmd[1:0], rw, data[1:0], sc_st, sc_dn, sc_dn_done, pf_st, pf_dn, pf_done, rp, ro}.
module tb_tx_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       sc_reserve, sc_valid, sc_reply_wanted;
   logic [1:0] sc_command, sc_data;
   logic       sc_started, sc_data_next, sc_done;
   logic       pf_valid, pf_reply_wanted;
   logic [1:0] pf_command, pf_data;
   logic       pf_started, pf_data_next, pf_done;
   logic       tx_command_valid, tx_reply_wanted;
   logic [1:0] tx_command, tx_data;
   logic       tx_command_started, tx_data_next, tx_done, rx_done;
   logic       reply_pending, reply_owner;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      string      name;
      logic       rst, res, scv;
      logic [1:0] scc;
      logic       scr;
      logic [1:0] scd;
      logic       pfv;
      logic [1:0] pfc;
      logic       pfr;
      logic [1:0] pfd;
      logic [3:0] strb;   // {tx_command_started, tx_data_next, tx_done, rx_done}
      logic [13:0] exp;
   } vec_t;

   vec_t vecs[$];

   tx_arbiter #(.NSHIFT(2), .CMD_BITS(2)) dut (
      .clk(clk), .reset(reset),
      .sc_reserve(sc_reserve), .sc_valid(sc_valid), .sc_command(sc_command),
      .sc_reply_wanted(sc_reply_wanted), .sc_data(sc_data),
      .sc_started(sc_started), .sc_data_next(sc_data_next), .sc_done(sc_done),
      .pf_valid(pf_valid), .pf_command(pf_command), .pf_reply_wanted(pf_reply_wanted),
      .pf_data(pf_data), .pf_started(pf_started), .pf_data_next(pf_data_next), .pf_done(pf_done),
      .tx_command_valid(tx_command_valid), .tx_command(tx_command),
      .tx_reply_wanted(tx_reply_wanted), .tx_data(tx_data),
      .tx_command_started(tx_command_started), .tx_data_next(tx_data_next),
      .tx_done(tx_done), .rx_done(rx_done),
      .reply_pending(reply_pending), .reply_owner(reply_owner)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] outs();
      return {tx_command_valid, tx_command, tx_reply_wanted, tx_data,
              sc_started, sc_data_next, sc_done,
              pf_started, pf_data_next, pf_done, reply_pending, reply_owner};
   endfunction

   task automatic add(input string nm, input logic rst, input logic res, input logic scv,
                      input logic [1:0] scc, input logic scr, input logic [1:0] scd,
                      input logic pfv, input logic [1:0] pfc, input logic pfr,
                      input logic [1:0] pfd, input logic [3:0] strb, input logic [13:0] exp);
      vec_t v;
      v.name = nm; v.rst = rst; v.res = res; v.scv = scv; v.scc = scc; v.scr = scr;
      v.scd = scd; v.pfv = pfv; v.pfc = pfc; v.pfr = pfr; v.pfd = pfd; v.strb = strb;
      v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      reset = v.rst; sc_reserve = v.res; sc_valid = v.scv; sc_command = v.scc;
      sc_reply_wanted = v.scr; sc_data = v.scd; pf_valid = v.pfv; pf_command = v.pfc;
      pf_reply_wanted = v.pfr; pf_data = v.pfd;
      {tx_command_started, tx_data_next, tx_done, rx_done} = v.strb;
   endtask

   task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   // one cycle: drive after the rising edge, compare on the falling edge
   task automatic step(input vec_t v);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      check(v.name, outs(), v.exp);
   endtask

   vec_t h;

   initial begin
      // ---------------- table ----------------
      //   name         rst  res  scv  scc   scr  scd   pfv  pfc   pfr  pfd   strb     exp
      add("rst_idle",   1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0000,14'b0_00_0_00_000_000_0_0);
      add("sc_req",     1'b0,1'b0,1'b1,2'b01,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0000,14'b0_00_0_00_000_000_0_0);
      add("sc_start",   1'b0,1'b0,1'b1,2'b01,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,4'b1000,14'b1_01_0_00_100_000_0_0);
      add("sc_dnext",   1'b0,1'b0,1'b0,2'b01,1'b0,2'b10,1'b0,2'b00,1'b0,2'b00,4'b0100,14'b0_01_0_10_010_000_0_0);
      add("sc_done",    1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0010,14'b0_01_0_00_001_000_0_0);
      add("idle_after", 1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0000,14'b0_00_0_00_000_000_0_0);
      add("both_req",   1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,1'b1,2'b11,1'b0,2'b00,4'b0000,14'b0_00_0_00_000_000_0_0);
      add("both_sc_st", 1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,1'b1,2'b11,1'b0,2'b00,4'b1000,14'b1_10_0_00_100_000_0_0);
      add("both_sc_dn", 1'b0,1'b0,1'b0,2'b10,1'b0,2'b00,1'b1,2'b11,1'b0,2'b00,4'b0010,14'b0_10_0_00_001_000_0_0);
      add("gap_idle",   1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b11,1'b0,2'b00,4'b0000,14'b0_00_0_00_000_000_0_0);
      add("pf_start",   1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b11,1'b0,2'b00,4'b1000,14'b1_11_0_00_000_100_0_0);
      add("pf_data0",   1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,1'b0,2'b11,1'b0,2'b00,4'b0100,14'b0_11_0_00_000_010_0_0);
      add("pf_data1",   1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,1'b0,2'b11,1'b0,2'b01,4'b0100,14'b0_11_0_01_000_010_0_0);
      add("pf_data2",   1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,1'b0,2'b11,1'b0,2'b10,4'b0100,14'b0_11_0_10_000_010_0_0);
      add("pf_data3",   1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,1'b0,2'b11,1'b0,2'b11,4'b0100,14'b0_11_0_11_000_010_0_0);
      add("pf_done",    1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,1'b0,2'b11,1'b0,2'b00,4'b0010,14'b0_11_0_00_000_001_0_0);
      add("idle_strb",  1'b0,1'b0,1'b0,2'b00,1'b1,2'b11,1'b0,2'b00,1'b1,2'b10,4'b1110,14'b0_00_0_00_000_000_0_0);
      add("idle_still", 1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0000,14'b0_00_0_00_000_000_0_0);
      add("pfr_req",    1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b01,1'b1,2'b00,4'b0000,14'b0_00_0_00_000_000_0_0);
      add("pfr_start",  1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b01,1'b1,2'b00,4'b1000,14'b1_01_1_00_000_100_0_0);
      add("pfr_pend",   1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,1'b0,2'b01,1'b1,2'b00,4'b0000,14'b0_01_1_00_000_000_1_0);
      add("pfr_done",   1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,1'b0,2'b01,1'b1,2'b00,4'b0010,14'b0_01_1_00_000_001_1_0);
      add("scr_held1",  1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0000,14'b0_00_0_00_000_000_1_0);
      add("scr_held2",  1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0000,14'b0_00_0_00_000_000_1_0);
      add("scr_rxdone", 1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0001,14'b0_00_0_00_000_000_1_0);
      add("scr_freed",  1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0000,14'b0_00_0_00_000_000_0_0);
      add("scr_start",  1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,1'b0,2'b00,1'b0,2'b00,4'b1000,14'b1_10_1_00_100_000_0_0);
      add("scr_done",   1'b0,1'b0,1'b0,2'b10,1'b1,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0010,14'b0_10_1_00_001_000_1_1);
      add("own_sc",     1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0000,14'b0_00_0_00_000_000_1_1);
      add("sc0_req",    1'b0,1'b0,1'b1,2'b01,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0000,14'b0_00_0_00_000_000_1_1);
      add("sc0_start",  1'b0,1'b0,1'b1,2'b01,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,4'b1000,14'b1_01_0_00_100_000_1_1);
      add("sc0_done",   1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0010,14'b0_01_0_00_001_000_1_1);
      add("pfr_held",   1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b10,1'b1,2'b00,4'b0000,14'b0_00_0_00_000_000_1_1);
      add("pfr_rxdone", 1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b10,1'b1,2'b00,4'b0001,14'b0_00_0_00_000_000_1_1);
      add("pfr_freed",  1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b10,1'b1,2'b00,4'b0000,14'b0_00_0_00_000_000_0_1);
      add("set_vs_clr", 1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b10,1'b1,2'b00,4'b1001,14'b1_10_1_00_000_100_0_1);
      add("set_wins",   1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b10,1'b1,2'b00,4'b0010,14'b0_10_1_00_000_001_1_0);
      add("rx_clear",   1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0001,14'b0_00_0_00_000_000_1_0);
      add("cleared",    1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,4'b0000,14'b0_00_0_00_000_000_0_0);

      // ---------------- reset ----------------
      h = vecs[0];
      h.rst = 1'b1;
      drive(h);
      @(posedge clk);
      @(negedge clk);
      check("reset_state", outs(), 14'b0);

      // ---------------- table loop ----------------
      foreach (vecs[i]) step(vecs[i]);

      // ---------------- sc_reserve blocks PF for 10 cycles ----------------
      h = vecs[0];
      h.res = 1'b1; h.pfv = 1'b1; h.pfc = 2'b10;
      for (int i = 0; i < 10; i++) begin
         h.name = $sformatf("reserve_hold%0d", i);
         h.exp  = 14'b0;
         step(h);
      end
      h.res = 1'b0; h.name = "reserve_drop"; h.exp = 14'b0;
      step(h);
      // granted now; SC reserving/requesting must not preempt PF
      h.res = 1'b1; h.scv = 1'b1; h.scc = 2'b01; h.name = "pf_no_preempt";
      h.exp = 14'b1_10_0_00_000_000_0_0;
      step(h);
      h.strb = 4'b0010; h.name = "pf_done_res";
      h.exp = 14'b1_10_0_00_000_001_0_0;
      step(h);
      h.strb = 4'b0000; h.pfv = 1'b0; h.name = "sc_after_gap";
      h.exp = 14'b0;
      step(h);
      h.name = "sc_granted"; h.exp = 14'b1_01_0_00_000_000_0_0;
      step(h);
      h.strb = 4'b0010; h.scv = 1'b0; h.res = 1'b0; h.name = "sc_close";
      h.exp = 14'b0_01_0_00_001_000_0_0;
      step(h);

      // ---------------- reset mid-payload in GRANT_SC ----------------
      h = vecs[0];
      h.scv = 1'b1; h.scc = 2'b11; h.scr = 1'b1; h.name = "mid_req"; h.exp = 14'b0;
      step(h);
      h.strb = 4'b1000; h.name = "mid_start"; h.exp = 14'b1_11_1_00_100_000_0_0;
      step(h);
      h.strb = 4'b0100; h.scv = 1'b0; h.scd = 2'b01; h.name = "mid_payload";
      h.exp = 14'b0_11_1_01_010_000_1_1;
      step(h);
      h.rst = 1'b1; h.name = "mid_reset"; h.exp = 14'b0_11_1_01_010_000_1_1;
      step(h);
      h.rst = 1'b0; h.strb = 4'b0110; h.name = "post_reset"; h.exp = 14'b0;
      step(h);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
